lsu_bus_req_queue: RTL
======================

// Module: lsu_bus_req_queue
// PURPOSE
//  In-order request queue between the LSQ and lsu_bus_ctrl for uncached/IO loads, stores and fences.
//  Decouples LSQ issue from the multi-beat Wishbone transaction: LSQ keeps issuing while a bus access is in flight.
//  Holds a fence at the queue head until the bus controller is idle.
//  Presents requests to lsu_bus_ctrl with its vld/rdy protocol and field set unchanged.
// PARAMETERS
//  DEPTH       4                          entries; power of 2, >=2
//  ENTRY_W     derived                    1+1+ROB_INDEX_WIDTH+PHY_REG_ADDR_WIDTH+STU_OP_WIDTH+PHYSICAL_ADDR_LEN+XLEN
// PORTS
//  clk                        in   1     clock
//  rstn                       in   1     async reset, active low
//  flush                      in   1     sync pipeline flush
//  lsq_req_vld_i              in   1     LSQ request valid
//  req_queue_lsq_rdy_o        out  1     queue can accept
//  lsq_req_load_or_store_i    in   1     1=store, 0=load
//  lsq_req_is_fence_i         in   1     fence marker
//  lsq_req_rob_index_i        in   ROB_INDEX_WIDTH     ROB tag
//  lsq_req_rd_addr_i          in   PHY_REG_ADDR_WIDTH  load destination
//  lsq_req_opcode_i           in   STU_OP_WIDTH        LDU_*/STU_* opcode
//  lsq_req_paddr_i            in   PHYSICAL_ADDR_LEN   physical address
//  lsq_req_data_i             in   XLEN                store data
//  req_queue_bus_ctrl_vld_o   out  1     head valid toward lsu_bus_ctrl
//  bus_ctrl_req_queue_rdy_i   in   1     lsu_bus_ctrl ready
//  req_queue_bus_ctrl_*_o     out  --    load_or_store/is_fence/rob_index/rd_addr/opcode/paddr/data of head, widths as inputs
//  bus_ctrl_idle_i            in   1     lsu_bus_ctrl holds no request
//  req_queue_cnt_o            out  $clog2(DEPTH)+1  occupancy
//  req_queue_empty_o          out  1     cnt==0
// BEHAVIOUR
//  - Circular buffer; wr_ptr/rd_ptr $clog2(DEPTH)+1 bits, MSB = wrap bit. full: indices equal, wrap bits differ; empty: pointers equal.
//  - Reset (rstn low, async): pointers 0; vld_o=0, rdy_o=1, cnt_o=0, empty_o=1; payload outputs 0. Storage not reset.
//  - rdy_o = ~full (full blocks enqueue even if a dequeue fires in the same cycle). enq = lsq_req_vld_i & rdy_o.
//  - vld_o = ~empty & (~head.is_fence | bus_ctrl_idle_i). deq = vld_o & bus_ctrl_req_queue_rdy_i.
//  - Payload outputs are the head entry (combinational read); stable while vld_o & ~rdy_i.
//  - Latency enqueue -> vld_o: 1 cycle (no bypass build). Strict FIFO order; no merging, no reordering.
//  - Simultaneous enq & deq (not full): both happen; cnt unchanged. Pointers wrap modulo 2*DEPTH.
//  - Fence at head: vld_o stays 0 until bus_ctrl_idle_i=1, then it dequeues like any entry; entries behind it wait.
//  - flush: next edge pointers 0, queue empty; flush overrides enq and deq in the same cycle.
//  - rstn asserted mid-operation: all state cleared immediately; no request is replayed.
// CONFIGURATION
//  LSU_BUS_REQ_QUEUE_BYPASS_EN defined: when queue empty, enq & (~lsq_req_is_fence_i | bus_ctrl_idle_i) & bus_ctrl_req_queue_rdy_i & ~flush,
//    the LSQ request drives vld_o and the payload outputs the same cycle (0 latency) and is not written; otherwise written as usual.
//  Not defined: no combinational LSQ->bus_ctrl path; 1-cycle minimum latency.
// STRUCTURE
//  Opcodes (LDU_*/STU_*) and widths (XLEN, ROB_INDEX_WIDTH, PHY_REG_ADDR_WIDTH, STU_OP_WIDTH, PHYSICAL_ADDR_LEN) come from params.vh.
//  Entry packing/field offsets are localparams in this file. Single flat module; no sub-module.
// TESTING
//  1. Reset, then 4 loads (rob 1..4), rdy_i=1 -> vld_o the cycle after each enq; rob 1,2,3,4 out in order; cnt returns to 0.
//  2. DEPTH=4, rdy_i=0, push 5 -> rdy_o=0 after 4th, 5th held at LSQ; cnt=4; rdy_i=1 one cycle -> rob 1 out; 5th enqueued next cycle.
//  3. Store, fence, load queued, bus_ctrl_idle_i=0 -> store out, fence held (vld_o=0) 3 cycles; idle=1 -> fence then load out.
//  4. 3 entries queued, flush with lsq_req_vld_i=1 -> next cycle empty_o=1, cnt=0, vld_o=0; flushed-cycle request absent.
//  5. rstn low mid-stream with 2 entries -> vld_o=0, cnt=0 immediately, before the next clk edge.
//  6. BYPASS_EN, empty, rdy_i=1, load rob 7 -> vld_o=1 with rob 7 same cycle, cnt stays 0; repeated with fence and idle=0 -> written, cnt=1.

Source files
------------

// File: rtl/lsu_bus_req_queue_pkg.sv
// Shared widths, opcodes and the request entry layout for lsu_bus_req_queue.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lsu_bus_req_queue_pkg;

  // Core-wide widths
  localparam int XLEN               = 64;
  localparam int ROB_INDEX_WIDTH    = 5;
  localparam int PHY_REG_ADDR_WIDTH = 6;
  localparam int STU_OP_WIDTH       = 5;
  localparam int PHYSICAL_ADDR_LEN  = 56;

  // LSU opcodes carried through the queue untouched
  localparam logic [STU_OP_WIDTH-1:0] LDU_LW    = 5'd2;
  localparam logic [STU_OP_WIDTH-1:0] LDU_LD    = 5'd3;
  localparam logic [STU_OP_WIDTH-1:0] STU_SD    = 5'd11;
  localparam logic [STU_OP_WIDTH-1:0] STU_FENCE = 5'd16;

  // One queued request. Field order fixes the packing: load_or_store is the MSB,
  // data occupies the low XLEN bits.
  typedef struct packed {
    logic                          load_or_store;
    logic                          is_fence;
    logic [ROB_INDEX_WIDTH-1:0]    rob_index;
    logic [PHY_REG_ADDR_WIDTH-1:0] rd_addr;
    logic [STU_OP_WIDTH-1:0]       opcode;
    logic [PHYSICAL_ADDR_LEN-1:0]  paddr;
    logic [XLEN-1:0]               data;
  } req_entry_t;

  localparam int ENTRY_W = $bits(req_entry_t);

endpackage

// File: rtl/lsu_bus_req_queue.sv
// In-order queue of uncached/IO loads, stores and fences between the LSQ and lsu_bus_ctrl.
// Latency: 1 cycle enqueue->vld_o; 0 cycles when LSU_BUS_REQ_QUEUE_BYPASS_EN is defined and the queue is empty.
// Backpressure: rdy_o drops only when full; a fence at the head holds vld_o low until the bus controller is idle.
module lsu_bus_req_queue
  import lsu_bus_req_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          flush,

  input  logic                          lsq_req_vld_i,
  output logic                          req_queue_lsq_rdy_o,
  input  logic                          lsq_req_load_or_store_i,
  input  logic                          lsq_req_is_fence_i,
  input  logic [ROB_INDEX_WIDTH-1:0]    lsq_req_rob_index_i,
  input  logic [PHY_REG_ADDR_WIDTH-1:0] lsq_req_rd_addr_i,
  input  logic [STU_OP_WIDTH-1:0]       lsq_req_opcode_i,
  input  logic [PHYSICAL_ADDR_LEN-1:0]  lsq_req_paddr_i,
  input  logic [XLEN-1:0]               lsq_req_data_i,

  output logic                          req_queue_bus_ctrl_vld_o,
  input  logic                          bus_ctrl_req_queue_rdy_i,
  output logic                          req_queue_bus_ctrl_load_or_store_o,
  output logic                          req_queue_bus_ctrl_is_fence_o,
  output logic [ROB_INDEX_WIDTH-1:0]    req_queue_bus_ctrl_rob_index_o,
  output logic [PHY_REG_ADDR_WIDTH-1:0] req_queue_bus_ctrl_rd_addr_o,
  output logic [STU_OP_WIDTH-1:0]       req_queue_bus_ctrl_opcode_o,
  output logic [PHYSICAL_ADDR_LEN-1:0]  req_queue_bus_ctrl_paddr_o,
  output logic [XLEN-1:0]               req_queue_bus_ctrl_data_o,

  input  logic                          bus_ctrl_idle_i,
  output logic [$clog2(DEPTH):0]        req_queue_cnt_o,
  output logic                          req_queue_empty_o
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = PTR_W - 1;

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0]   wr_idx, rd_idx;
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  req_entry_t lsq_entry;
  req_entry_t head_entry;
  req_entry_t out_entry;

  logic full;
  logic empty;
  logic enq;
  logic wr_en;
  logic head_vld;
  logic deq;
  logic out_vld;
  logic bypass;

  assign wr_idx = wr_ptr_q[IDX_W-1:0];
  assign rd_idx = rd_ptr_q[IDX_W-1:0];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_idx == rd_idx) && (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]);

  // Full blocks enqueue even when the head leaves in the same cycle; this keeps
  // rdy_o free of any dependence on the bus controller's ready.
  assign req_queue_lsq_rdy_o = ~full;
  assign enq                 = lsq_req_vld_i & ~full;

  // Gather the LSQ request fields into one entry.
  always_comb begin
    lsq_entry               = '0;
    lsq_entry.load_or_store = lsq_req_load_or_store_i;
    lsq_entry.is_fence      = lsq_req_is_fence_i;
    lsq_entry.rob_index     = lsq_req_rob_index_i;
    lsq_entry.rd_addr       = lsq_req_rd_addr_i;
    lsq_entry.opcode        = lsq_req_opcode_i;
    lsq_entry.paddr         = lsq_req_paddr_i;
    lsq_entry.data          = lsq_req_data_i;
  end

  // Head is read combinationally; a fence may only leave once the bus side has drained.
  assign head_entry = req_entry_t'(mem_q[rd_idx]);
  assign head_vld   = ~empty & (~head_entry.is_fence | bus_ctrl_idle_i);
  assign deq        = head_vld & bus_ctrl_req_queue_rdy_i;

`ifdef LSU_BUS_REQ_QUEUE_BYPASS_EN
  // An empty queue hands an acceptable request straight through when the bus takes it
  // this cycle; such a request never occupies storage.
  assign bypass = empty & enq & (~lsq_req_is_fence_i | bus_ctrl_idle_i)
                & bus_ctrl_req_queue_rdy_i & ~flush;
`else
  // No combinational LSQ->bus_ctrl path: every request is stored first.
  assign bypass = 1'b0;
`endif

  assign wr_en = enq & ~bypass & ~flush;

  // Select what is presented to the bus controller; payload reads as zero while empty.
  always_comb begin
    out_vld   = head_vld;
    out_entry = empty ? '0 : head_entry;
    if (bypass) begin
      out_vld   = 1'b1;
      out_entry = lsq_entry;
    end
  end

  assign req_queue_bus_ctrl_vld_o           = out_vld;
  assign req_queue_bus_ctrl_load_or_store_o = out_entry.load_or_store;
  assign req_queue_bus_ctrl_is_fence_o      = out_entry.is_fence;
  assign req_queue_bus_ctrl_rob_index_o     = out_entry.rob_index;
  assign req_queue_bus_ctrl_rd_addr_o       = out_entry.rd_addr;
  assign req_queue_bus_ctrl_opcode_o        = out_entry.opcode;
  assign req_queue_bus_ctrl_paddr_o         = out_entry.paddr;
  assign req_queue_bus_ctrl_data_o          = out_entry.data;

  // Occupancy falls out of the wrap-bit pointers directly (modulo 2*DEPTH).
  assign req_queue_cnt_o   = wr_ptr_q - rd_ptr_q;
  assign req_queue_empty_o = empty;

  // Next pointers: flush wins over any enqueue or dequeue in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (deq)   rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer registers; reset empties the queue immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage is not reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= lsq_entry;
  end

endmodule
